// File: rtl/fc_frame_shift_buffer_if.sv
// Handshake and frame bus between a serial activation producer, the shift buffer,
// and the parallel multiply-array consumer.
interface fc_frame_shift_buffer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUTS     = 84,
    parameter int COUNT_WIDTH     = $clog2(NUM_OUTPUTS + 1),
    parameter int FRAME_CNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic                              flush;
    logic                              frame_ack;
    logic                              frame_valid;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_out;
    logic [COUNT_WIDTH-1:0]            word_count;
    logic [FRAME_CNT_WIDTH-1:0]        frames_done;

    modport master (
        output in_data, in_valid, flush, frame_ack,
        input  in_ready, frame_valid, data_out, word_count, frames_done
    );

    modport slave (
        input  in_data, in_valid, flush, frame_ack,
        output in_ready, frame_valid, data_out, word_count, frames_done
    );
endinterface

// File: rtl/fc_frame_shift_buffer.sv
// Serial-to-parallel activation buffer: shifts words into a NUM_OUTPUTS-deep chain
// and holds the completed frame until the consumer acknowledges it.
//
//   state | meaning
//   LOAD  | accepting words, frame incomplete, in_ready=1
//   FULL  | frame complete and frozen on data_out until frame_ack
module fc_frame_shift_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUTS     = 84,
    parameter int COUNT_WIDTH     = $clog2(NUM_OUTPUTS + 1),
    parameter int FRAME_CNT_WIDTH = 16
) (
    input logic                     clk,
    input logic                     reset,
    fc_frame_shift_buffer_if.slave  bus
);
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(NUM_OUTPUTS - 1);

    state_t                            state_q;
    state_t                            state_d;
    logic                              in_ready;
    logic                              accept;
    logic                              ack_take;
    logic [DATA_WIDTH-1:0]             slot_q [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0]            count_q;
    logic [FRAME_CNT_WIDTH-1:0]        frames_q;
    logic                              frame_valid_q;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_flat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: if (accept && count_q == LAST_IDX) state_d = FULL;
                FULL: if (bus.frame_ack) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    // flush discards any word offered in the same cycle and overrides an ack
    always_comb begin
        in_ready = (state_q == LOAD);
        accept   = bus.in_valid && in_ready && !bus.flush;
        ack_take = (state_q == FULL) && bus.frame_ack && !bus.flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                slot_q[k] <= '0;
            end
            count_q       <= '0;
            frames_q      <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= (state_d == FULL);
            if (bus.flush) begin
                count_q <= '0;
            end else if (accept) begin
                for (int k = 0; k < NUM_OUTPUTS - 1; k++) begin
                    slot_q[k] <= slot_q[k+1];
                end
                slot_q[NUM_OUTPUTS-1] <= bus.in_data;
                count_q               <= count_q + COUNT_WIDTH'(1);
            end else if (ack_take) begin
                count_q  <= '0;
                frames_q <= frames_q + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    // slot 0 is the oldest word once the frame is full
    always_comb begin
        data_flat = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            data_flat[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.frame_valid = frame_valid_q;
    assign bus.data_out    = data_flat;
    assign bus.word_count  = count_q;
    assign bus.frames_done = frames_q;
endmodule

// File: tb/tb_fc_frame_shift_buffer.sv
// Bench for fc_frame_shift_buffer: directed vector table, corner sequences and
// randomized traffic against a word-history reference model.
module tb_fc_frame_shift_buffer;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);
    localparam int FW = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fc_frame_shift_buffer_if #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N), .COUNT_WIDTH(CW),
                               .FRAME_CNT_WIDTH(FW)) bus ();

    fc_frame_shift_buffer #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N), .COUNT_WIDTH(CW),
                            .FRAME_CNT_WIDTH(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the chain always shows the last N accepted words since reset
    bit           m_full;
    int           m_cnt;
    int           m_frames;
    logic [DW-1:0] hist[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic f, input logic v,
                              input logic [DW-1:0] d, input logic a);
        if (r) begin
            m_full = 0; m_cnt = 0; m_frames = 0;
            hist.delete();
        end else if (f) begin
            m_full = 0; m_cnt = 0;
        end else if (!m_full) begin
            if (v) begin
                hist.push_back(d);
                if (hist.size() > N) void'(hist.pop_front());
                m_cnt++;
                if (m_cnt == N) m_full = 1;
            end
        end else if (a) begin
            m_full = 0; m_cnt = 0;
            m_frames = (m_frames + 1) % (1 << FW);
        end
    endtask

    function automatic logic [N*DW-1:0] model_dout();
        logic [N*DW-1:0] r;
        int pad;
        r   = '0;
        pad = N - hist.size();
        for (int k = pad; k < N; k++) r[k*DW +: DW] = hist[k - pad];
        return r;
    endfunction

    task automatic model_check();
        chk("mdl_ready",  64'(bus.in_ready),    64'(!m_full));
        chk("mdl_fvalid", 64'(bus.frame_valid), 64'(m_full));
        chk("mdl_count",  64'(bus.word_count),  64'(m_cnt));
        chk("mdl_frames", 64'(bus.frames_done), 64'(m_frames));
        chk("mdl_dout",   64'(bus.data_out),    64'(model_dout()));
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [DW-1:0] d, input logic a);
        reset         = r;
        bus.flush     = f;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.frame_ack = a;
        @(posedge clk);
        model_edge(r, f, v, d, a);
        #1;
        model_check();
    endtask

    task automatic push_frame(input logic [DW-1:0] base);
        for (int i = 0; i < N; i++) step(0, 0, 1, base + DW'(i), 0);
    endtask

    typedef struct {
        logic          rst;
        logic          fl;
        logic          v;
        logic [DW-1:0] d;
        logic          ack;
        logic          rdy;
        logic          fv;
        logic [CW-1:0] cnt;
        logic [FW-1:0] fr;
        logic [N*DW-1:0] dout;
    } vec_t;

    vec_t tbl[14];
    int   seq[5];
    logic [FW-1:0] fr_before;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus.flush = 0; bus.in_valid = 0; bus.in_data = '0; bus.frame_ack = 0;

        tbl[0]  = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 32'h00000000};
        tbl[1]  = '{0, 0, 1, 8'h11, 0, 1, 0, 1, 0, 32'h11000000};
        tbl[2]  = '{0, 0, 1, 8'h22, 0, 1, 0, 2, 0, 32'h22110000};
        tbl[3]  = '{0, 0, 1, 8'h33, 0, 1, 0, 3, 0, 32'h33221100};
        tbl[4]  = '{0, 0, 1, 8'h44, 0, 0, 1, 4, 0, 32'h44332211};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{0, 0, 1, 8'h99, 0, 0, 1, 4, 0, 32'h44332211};
        tbl[10] = '{0, 0, 1, 8'h99, 1, 1, 0, 0, 1, 32'h44332211};
        tbl[11] = '{0, 0, 1, 8'h99, 0, 1, 0, 1, 1, 32'h99443322};
        tbl[12] = '{0, 0, 0, 8'h55, 0, 1, 0, 1, 1, 32'h99443322};
        tbl[13] = '{0, 0, 0, 8'h00, 1, 1, 0, 1, 1, 32'h99443322};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].ack);
            chk($sformatf("vec%0d_ready", i),  64'(bus.in_ready),    64'(tbl[i].rdy));
            chk($sformatf("vec%0d_fvalid", i), 64'(bus.frame_valid), 64'(tbl[i].fv));
            chk($sformatf("vec%0d_count", i),  64'(bus.word_count),  64'(tbl[i].cnt));
            chk($sformatf("vec%0d_frames", i), 64'(bus.frames_done), 64'(tbl[i].fr));
            chk($sformatf("vec%0d_dout", i),   64'(bus.data_out),    64'(tbl[i].dout));
        end

        // idle cycles between accepts must not shift the chain
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 1, 8'hA1, 0);
        step(0, 0, 1, 8'hA2, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'hFF, 0);
            chk("idle_count", 64'(bus.word_count), 64'd2);
            chk("idle_dout_hi", 64'(bus.data_out[31:16]), 64'hA2A1);
        end
        step(0, 0, 1, 8'hA3, 0);
        step(0, 0, 1, 8'hA4, 0);
        chk("idle_final_dout", 64'(bus.data_out), 64'hA4A3A2A1);
        chk("idle_final_fv", 64'(bus.frame_valid), 64'd1);
        step(0, 0, 0, 8'h00, 1);

        // flush with a concurrent word discards it and leaves frames_done alone
        fr_before = bus.frames_done;
        step(0, 0, 1, 8'hB1, 0);
        step(0, 0, 1, 8'hB2, 0);
        step(0, 1, 1, 8'hEE, 0);
        chk("flush_count", 64'(bus.word_count), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        push_frame(8'h01);
        chk("flush_refill_dout", 64'(bus.data_out), 64'h04030201);
        chk("flush_refill_fv", 64'(bus.frame_valid), 64'd1);
        chk("flush_frames", 64'(bus.frames_done), 64'(fr_before));

        // flush beats ack in FULL
        step(0, 1, 0, 8'h00, 1);
        chk("flush_ack_fv", 64'(bus.frame_valid), 64'd0);
        chk("flush_ack_frames", 64'(bus.frames_done), 64'(fr_before));
        chk("flush_ack_ready", 64'(bus.in_ready), 64'd1);

        // reset mid-frame
        step(0, 0, 1, 8'hC1, 0);
        step(0, 0, 1, 8'hC2, 0);
        step(1, 0, 1, 8'hC3, 0);
        chk("rst_dout", 64'(bus.data_out), 64'd0);
        chk("rst_count", 64'(bus.word_count), 64'd0);
        chk("rst_frames", 64'(bus.frames_done), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);

        // frames_done wraps at 2^FW
        seq = '{1, 2, 3, 0, 1};
        for (int f = 0; f < 5; f++) begin
            push_frame(DW'(8'h10 * f));
            step(0, 0, 0, 8'h00, 1);
            chk($sformatf("wrap%0d_frames", f), 64'(bus.frames_done), 64'(seq[f]));
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 7),
                 DW'($urandom),
                 ($urandom_range(0, 9) < 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
